// File: rtl/id_ex_control_if.sv
// Decode-stage bundle between the IF/ID side (master) and the ID/EX control register (slave).
interface id_ex_control_if;
  logic [31:0] instr;
  logic        id_valid;
  logic        stall;
  logic        flush;
  logic        hazard_stall;
  logic        ex_valid;
  logic [1:0]  ALU_op;
  logic [2:0]  funct3;
  logic        bit30;
  logic        ALUSrc;
  logic        MemRead;
  logic        MemWrite;
  logic        RegWrite;
  logic        MemtoReg;
  logic        Branch;
  logic [4:0]  ex_rd;
  logic [4:0]  ex_rs1;
  logic [4:0]  ex_rs2;
  logic [7:0]  illegal_count;

  modport master (
    output instr, id_valid, stall, flush,
    input  hazard_stall, ex_valid, ALU_op, funct3, bit30, ALUSrc, MemRead,
           MemWrite, RegWrite, MemtoReg, Branch, ex_rd, ex_rs1, ex_rs2,
           illegal_count
  );

  modport slave (
    input  instr, id_valid, stall, flush,
    output hazard_stall, ex_valid, ALU_op, funct3, bit30, ALUSrc, MemRead,
           MemWrite, RegWrite, MemtoReg, Branch, ex_rd, ex_rs1, ex_rs2,
           illegal_count
  );
endinterface

// File: rtl/id_ex_control.sv
// RV32 main control decode, ID/EX control register, load-use hazard detect
// and saturating unsupported-opcode counter.
module id_ex_control (
  input  logic             clk,
  input  logic             reset,
  id_ex_control_if.slave   bus
);

  typedef struct packed {
    logic       valid;
    logic [1:0] alu_op;
    logic [2:0] funct3;
    logic       bit30;
    logic       alu_src;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       mem_to_reg;
    logic       branch;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
  } ctl_t;

  ctl_t       ctl_q, ctl_d, dec;
  logic [7:0] cnt_q, cnt_d;
  logic       rs1_used, rs2_used, illegal, hazard;
  logic [6:0] opcode;
  logic [4:0] rs1_f, rs2_f;
  logic       unused_bits;

  assign opcode      = bus.instr[6:0];
  assign rs1_f       = bus.instr[19:15];
  assign rs2_f       = bus.instr[24:20];
  assign unused_bits = ^{bus.instr[31], bus.instr[29:25]};

  always_comb begin
    dec            = '0;
    rs1_used       = 1'b0;
    rs2_used       = 1'b0;
    illegal        = 1'b0;
    dec.valid      = 1'b1;
    dec.funct3     = bus.instr[14:12];
    dec.rd         = bus.instr[11:7];
    dec.rs1        = rs1_f;
    dec.rs2        = rs2_f;
    case (opcode)
      7'b0110011: begin
        dec.alu_op    = 2'b10;
        dec.reg_write = 1'b1;
        dec.bit30     = bus.instr[30];
        rs1_used      = 1'b1;
        rs2_used      = 1'b1;
      end
      7'b0010011: begin
        // bit30 stays 0 so a negative immediate never selects subtract
        dec.alu_op    = 2'b10;
        dec.alu_src   = 1'b1;
        dec.reg_write = 1'b1;
        rs1_used      = 1'b1;
      end
      7'b0000011: begin
        dec.alu_src    = 1'b1;
        dec.mem_read   = 1'b1;
        dec.reg_write  = 1'b1;
        dec.mem_to_reg = 1'b1;
        rs1_used       = 1'b1;
      end
      7'b0100011: begin
        dec.alu_src   = 1'b1;
        dec.mem_write = 1'b1;
        rs1_used      = 1'b1;
        rs2_used      = 1'b1;
      end
      7'b1100011: begin
        dec.alu_op = 2'b01;
        dec.branch = 1'b1;
        rs1_used   = 1'b1;
        rs2_used   = 1'b1;
      end
      default: begin
        dec     = '0;
        illegal = 1'b1;
      end
    endcase
  end

  assign hazard = ctl_q.valid & ctl_q.mem_read & (ctl_q.rd != 5'd0) & bus.id_valid &
                  (((ctl_q.rd == rs1_f) & rs1_used) | ((ctl_q.rd == rs2_f) & rs2_used));

  always_comb begin
    ctl_d = ctl_q;
    cnt_d = cnt_q;
    if (bus.flush) begin
      ctl_d = '0;
    end else if (bus.stall) begin
      ctl_d = ctl_q;
    end else if (hazard) begin
      ctl_d = '0;
    end else begin
      ctl_d = bus.id_valid ? dec : '0;
      if (bus.id_valid && illegal && (cnt_q != 8'hFF))
        cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctl_q <= '0;
      cnt_q <= '0;
    end else begin
      ctl_q <= ctl_d;
      cnt_q <= cnt_d;
    end
  end

  assign bus.hazard_stall  = hazard;
  assign bus.ex_valid      = ctl_q.valid;
  assign bus.ALU_op        = ctl_q.alu_op;
  assign bus.funct3        = ctl_q.funct3;
  assign bus.bit30         = ctl_q.bit30;
  assign bus.ALUSrc        = ctl_q.alu_src;
  assign bus.MemRead       = ctl_q.mem_read;
  assign bus.MemWrite      = ctl_q.mem_write;
  assign bus.RegWrite      = ctl_q.reg_write;
  assign bus.MemtoReg      = ctl_q.mem_to_reg;
  assign bus.Branch        = ctl_q.branch;
  assign bus.ex_rd         = ctl_q.rd;
  assign bus.ex_rs1        = ctl_q.rs1;
  assign bus.ex_rs2        = ctl_q.rs2;
  assign bus.illegal_count = cnt_q;

endmodule

// File: tb/tb_id_ex_control.sv
// Directed bench for id_ex_control: decode, load-use hazard, flush/stall priority,
// illegal counter saturation and asynchronous reset.
module tb_id_ex_control;
  logic clk;
  logic reset;
  int   total;
  int   bad;

  id_ex_control_if b ();

  id_ex_control dut (
    .clk   (clk),
    .reset (reset),
    .bus   (b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [31:0] ADD   = 32'h002081B3;  // add x3,x1,x2
  localparam logic [31:0] SUB   = 32'h402081B3;  // sub x3,x1,x2
  localparam logic [31:0] ADDI  = 32'hFFF00093;  // addi x1,x0,-1
  localparam logic [31:0] LW5   = 32'h0000A283;  // lw x5,0(x1)
  localparam logic [31:0] DEP   = 32'h00228333;  // add x6,x5,x2
  localparam logic [31:0] LW0   = 32'h0000A003;  // lw x0,0(x1)
  localparam logic [31:0] DEP0  = 32'h00200333;  // add x6,x0,x2
  localparam logic [31:0] ADDI5 = 32'h00508313;  // addi x6,x1,5
  localparam logic [31:0] SW    = 32'h0020A023;  // sw x2,0(x1)
  localparam logic [31:0] BEQ   = 32'h00208063;  // beq x1,x2,0
  localparam logic [31:0] ILL   = 32'h0000007F;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  // {ex_valid, ALU_op, funct3, bit30, ALUSrc, MemRead, MemWrite, RegWrite, MemtoReg, Branch}
  function automatic logic [31:0] ctl();
    return {19'd0, b.ex_valid, b.ALU_op, b.funct3, b.bit30, b.ALUSrc, b.MemRead,
            b.MemWrite, b.RegWrite, b.MemtoReg, b.Branch};
  endfunction

  function automatic logic [31:0] regs();
    return {17'd0, b.ex_rd, b.ex_rs1, b.ex_rs2};
  endfunction

  task automatic drive(input logic [31:0] ins, input logic v, input logic st, input logic fl);
    b.instr    = ins;
    b.id_valid = v;
    b.stall    = st;
    b.flush    = fl;
  endtask

  task automatic step(input logic [31:0] ins, input logic v, input logic st, input logic fl);
    drive(ins, v, st, fl);
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    drive(32'h0, 1'b0, 1'b0, 1'b0);
    #3;
    chk("reset_ctl", ctl(), 32'h0);
    chk("reset_regs", regs(), 32'h0);
    chk("reset_cnt", {24'd0, b.illegal_count}, 32'h0);
    chk("reset_hz", {31'd0, b.hazard_stall}, 32'h0);
    #9 reset = 1'b0;  // t=12, first edge after release at t=15

    step(ADD, 1, 0, 0);
    chk("add_ctl", ctl(), {19'd0, 1'b1, 2'b10, 3'b000, 1'b0, 6'b000100});
    chk("add_regs", regs(), {17'd0, 5'd3, 5'd1, 5'd2});

    step(SUB, 1, 0, 0);
    chk("sub_ctl", ctl(), {19'd0, 1'b1, 2'b10, 3'b000, 1'b1, 6'b000100});

    step(ADDI, 1, 0, 0);
    chk("addi_ctl", ctl(), {19'd0, 1'b1, 2'b10, 3'b000, 1'b0, 6'b100100});
    chk("addi_rd", {27'd0, b.ex_rd}, 32'd1);

    step(SW, 1, 0, 0);
    chk("sw_ctl", ctl(), {19'd0, 1'b1, 2'b00, 3'b010, 1'b0, 6'b101000});
    step(BEQ, 1, 0, 0);
    chk("beq_ctl", ctl(), {19'd0, 1'b1, 2'b01, 3'b000, 1'b0, 6'b000001});

    // load-use: one bubble then the dependent add
    step(LW5, 1, 0, 0);
    chk("lw_ctl", ctl(), {19'd0, 1'b1, 2'b00, 3'b010, 1'b0, 6'b110110});
    drive(DEP, 1, 0, 0);
    #1;
    chk("lu_hz", {31'd0, b.hazard_stall}, 32'd1);
    step(DEP, 1, 0, 0);
    chk("lu_bubble", ctl(), 32'h0);
    chk("lu_bubble_regs", regs(), 32'h0);
    chk("lu_hz_drop", {31'd0, b.hazard_stall}, 32'd0);
    step(DEP, 1, 0, 0);
    chk("lu_dep_ctl", ctl(), {19'd0, 1'b1, 2'b10, 3'b000, 1'b0, 6'b000100});
    chk("lu_dep_regs", regs(), {17'd0, 5'd6, 5'd5, 5'd2});

    // unused rs2 field of I-type must not trigger a stall
    step(LW5, 1, 0, 0);
    drive(ADDI5, 1, 0, 0);
    #1;
    chk("lu_itype_hz", {31'd0, b.hazard_stall}, 32'd0);

    // x0 destination never stalls
    step(LW0, 1, 0, 0);
    drive(DEP0, 1, 0, 0);
    #1;
    chk("lu_x0_hz", {31'd0, b.hazard_stall}, 32'd0);

    // flush beats stall
    step(ADD, 1, 0, 0);
    step(SUB, 1, 1, 1);
    chk("flush_stall", ctl(), 32'h0);

    // stall holds for 3 cycles
    step(SUB, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(ADDI, 1, 1, 0);
      chk($sformatf("stall_ctl%0d", i), ctl(), {19'd0, 1'b1, 2'b10, 3'b000, 1'b1, 6'b000100});
      chk($sformatf("stall_regs%0d", i), regs(), {17'd0, 5'd3, 5'd1, 5'd2});
    end

    // stall with hazard: hold, stall request stays
    step(LW5, 1, 0, 0);
    step(DEP, 1, 1, 0);
    chk("stall_hz_ctl", ctl(), {19'd0, 1'b1, 2'b00, 3'b010, 1'b0, 6'b110110});
    chk("stall_hz_hz", {31'd0, b.hazard_stall}, 32'd1);

    // flush with hazard: single bubble
    step(DEP, 1, 0, 1);
    chk("flush_hz_ctl", ctl(), 32'h0);
    chk("flush_hz_hz", {31'd0, b.hazard_stall}, 32'd0);

    // illegal opcodes
    step(ILL, 1, 0, 0);
    chk("ill_cnt1", {24'd0, b.illegal_count}, 32'd1);
    chk("ill_ctl", ctl(), 32'h0);
    step(ILL, 1, 1, 0);
    chk("ill_stall_cnt", {24'd0, b.illegal_count}, 32'd1);
    step(ILL, 1, 0, 1);
    chk("ill_flush_cnt", {24'd0, b.illegal_count}, 32'd1);
    step(ILL, 0, 0, 0);
    chk("ill_novalid_cnt", {24'd0, b.illegal_count}, 32'd1);
    for (int i = 0; i < 299; i++) step(ILL, 1, 0, 0);
    chk("ill_sat", {24'd0, b.illegal_count}, 32'd255);
    chk("ill_sat_ctl", ctl(), 32'h0);

    // asynchronous reset mid-cycle with a load in EX and a stall pending
    step(LW5, 1, 0, 0);
    drive(DEP, 1, 0, 0);
    #1;
    chk("ar_pre_hz", {31'd0, b.hazard_stall}, 32'd1);
    #1 reset = 1'b1;
    #1;
    chk("ar_ctl", ctl(), 32'h0);
    chk("ar_regs", regs(), 32'h0);
    chk("ar_cnt", {24'd0, b.illegal_count}, 32'h0);
    chk("ar_hz", {31'd0, b.hazard_stall}, 32'h0);
    #1 reset = 1'b0;
    #1;
    chk("ar_release_ctl", ctl(), 32'h0);
    @(posedge clk);
    #1;
    chk("ar_first_ctl", ctl(), {19'd0, 1'b1, 2'b10, 3'b000, 1'b0, 6'b000100});
    chk("ar_first_regs", regs(), {17'd0, 5'd6, 5'd5, 5'd2});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/id_ex_control.md
# id_ex_control

Decode-stage main control unit and ID/EX control pipeline register for the pipelined RV32 core. It takes the IF/ID instruction word and produces the registered EX-stage controls, including the `ALU_op`/`funct3`/`bit30` triple consumed by the ALU control decoder. It also detects load-use hazards, applies stall and flush, and counts unsupported opcodes.

## Interface
- No parameters.
- `clk` input 1 — single clock; all state updates on the rising edge.
- `reset` input 1 — asynchronous, active-high.
- `instr` input 32 — IF/ID instruction word.
- `id_valid` input 1 — `instr` holds a real instruction.
- `stall` input 1 — external hold; the ID/EX register keeps its value.
- `flush` input 1 — inserts a bubble into ID/EX (branch redirect).
- `hazard_stall` output 1 — combinational load-use stall request to PC and IF/ID.
- `ex_valid` output 1 — ID/EX holds a real instruction.
- `ALU_op` output 2 — 00 add, 01 sub, 10 funct-decoded; 11 is never driven.
- `funct3` output 3 — registered `instr[14:12]`.
- `bit30` output 1 — registered `instr[30]` for R-type; 0 otherwise.
- `ALUSrc`, `MemRead`, `MemWrite`, `RegWrite`, `MemtoReg`, `Branch` outputs 1 each — registered controls.
- `ex_rd`, `ex_rs1`, `ex_rs2` outputs 5 each — registered register fields.
- `illegal_count` output 8 — saturating count of unsupported opcodes accepted.

## Operation
Decode is driven by `opcode = instr[6:0]`, with `id_valid`=1. Controls not named below are 0.
- R-type, 0110011: `ALU_op`=10, `RegWrite`=1, `bit30`=`instr[30]`. Uses rs1 and rs2.
- I-arith, 0010011: `ALU_op`=10, `ALUSrc`=1, `RegWrite`=1, `bit30` forced to 0. This keeps a negative immediate from selecting subtract. Uses rs1.
- Load, 0000011: `ALU_op`=00, `ALUSrc`, `MemRead`, `RegWrite`, `MemtoReg`=1. Uses rs1.
- Store, 0100011: `ALU_op`=00, `ALUSrc`, `MemWrite`=1. Uses rs1 and rs2.
- Branch, 1100011: `ALU_op`=01, `Branch`=1. Uses rs1 and rs2.
- Any other opcode: decodes as a bubble. If it is loaded into ID/EX, `illegal_count` increments and saturates at 255.

Bubble definition:
- `ex_valid`, all 1-bit controls, `ALU_op`, `funct3` and `bit30` are 0.
- Register fields are 0.
- With these values, ALU control resolves to add.

Load-use hazard:
- `hazard_stall` = `ex_valid` & `MemRead` & (`ex_rd`≠0) & `id_valid` & ((`ex_rd`==rs1 & rs1 used) | (`ex_rd`==rs2 & rs2 used)).
- It is evaluated against the current ID/EX contents and is purely combinational.

ID/EX update priority at each edge:
1. `flush` → load a bubble.
2. Otherwise `stall` → hold all registers; `illegal_count` unchanged.
3. Otherwise `hazard_stall` → load a bubble. The instruction stays in IF/ID because upstream is held.
4. Otherwise → load the decoded `instr`. If `id_valid`=0, load a bubble.

`illegal_count` increments only on case 4 with `id_valid`=1 and an unsupported opcode.

## Timing
- Decode-to-EX latency is 1 cycle: the instruction presented before edge N appears on the outputs after edge N.
- A load-use hazard adds exactly one bubble. On the next cycle, ID/EX holds that bubble, so `hazard_stall` deasserts and the dependent instruction enters.
- `flush` and `hazard_stall` in the same cycle: flush wins. The result is one bubble, and the held IF/ID instruction is discarded by upstream.
- `stall` with `hazard_stall`: hold, no bubble. `hazard_stall` stays asserted while the load remains in EX.
- Reset (asynchronous, at any time including mid-stall):
  - All outputs except `hazard_stall` go to 0 immediately, and `illegal_count`=0.
  - `hazard_stall` is 0 while in reset, because `ex_valid`=0.
  - The first load occurs on the first edge after `reset` deasserts.

## Test plan
- **R-type add.** `instr`=0x002081B3 (add x3,x1,x2), `id_valid`=1. After one edge: `ALU_op`=10, `funct3`=000, `bit30`=0, `RegWrite`=1, `ex_rd`=3, `ex_rs1`=1, `ex_rs2`=2.
- **R-type sub vs I-arith.**
  - `instr`=0x402081B3 (sub) → `bit30`=1.
  - `instr`=0xFFF00093 (addi x1,x0,-1) → `ALU_op`=10, `bit30`=0, `ALUSrc`=1.
- **Load-use hazard.** Apply 0x0000A283 (lw x5,0(x1)), then 0x00228333 (add x6,x5,x2).
  - In the cycle after the lw edge: `hazard_stall`=1.
  - Next edge: `ex_valid`=0 (bubble).
  - Following edge: add enters with `ex_rs1`=5.
  - Same lw with `ex_rd`=0 → `hazard_stall`=0.
- **Flush/stall priority.**
  - `flush`=1 together with `stall`=1 → bubble loaded.
  - `stall`=1 alone for 3 cycles → outputs unchanged.
  - `flush`=1 with `hazard_stall`=1 → a single bubble.
- **Illegal opcodes.** 300 consecutive `instr`=0x0000007F → `illegal_count`=255 (saturated) and all controls 0. With `stall`=1, the count does not advance.
- **Asynchronous reset.** Assert `reset` mid-cycle while a load is in EX and `hazard_stall`=1 → all outputs 0 before the next edge. After deassertion, the first instruction appears one edge later.
